weight_update: RTL
==================

Name: weight_update

Overview:
- Consumer end of the delta-weight stream. Sequences `Up_W` to shift the recorded-input register out one bit per cycle.
- Captures each `delta_w` sample, scales it by a power-of-two learning rate and saturating-adds it into the matching entry of an on-chip weight memory.
- Also provides a registered read port so the hypothesis/inference path can fetch weights while the block is idle.

Parameters:
- N_INPUTS, 8001: number of weights; equals recorded-input shift length.
- W_WIDTH, 16: signed weight width.
- LR_SHIFT, 0: learning rate as a power of two; step = delta <<< LR_SHIFT.
- AW, $clog2(N_INPUTS): address width.

Ports:
- Clk  in  1  clock.
- RST  in  1  reset: synchronous, active-high; clock Clk.
- Start  in  1  request one update pass; sampled only in IDLE.
- Delta_w  in  8  signed delta for the current index; valid in any cycle Up_W=1.
- Up_W  out  1  shift request to the delta producer; one pulse per index.
- Busy  out  1  high in any state other than IDLE.
- Done  out  1  one-cycle pulse when an update pass completes.
- Rd_addr  in  AW  weight read address.
- Rd_data  out  W_WIDTH  signed weight, one-cycle latency.

Behaviour:
- States: CLEAR, IDLE, UPDATE, DRAIN. Index counter `idx` is AW bits wide.
- Reset: state<=CLEAR, idx<=0, Up_W=0, Done=0, Rd_data<=0, pipeline valid<=0. Busy is 1 immediately after reset.
- CLEAR:
  - Writes 0 to address idx each cycle, idx++.
  - After writing N_INPUTS-1, goes to IDLE with idx<=0.
  - Lasts exactly N_INPUTS cycles. Start is ignored.
- IDLE:
  - Start=1 at an edge -> UPDATE, idx<=0.
  - RAM read port serves Rd_addr; Rd_data is updated one cycle later.
- UPDATE, per cycle:
  - Up_W=1 (combinational from state).
  - Issue RAM read of idx.
  - Register Delta_w and idx into stage-2 with valid=1.
  - idx++. At idx==N_INPUTS-1 -> DRAIN.
  - Up_W is high exactly N_INPUTS consecutive cycles.
- Stage 2, the cycle after capture:
  - sum = rd_q + sext(delta) <<< LR_SHIFT, computed at W_WIDTH+9 bits.
  - Saturate to [-2^(W_WIDTH-1), 2^(W_WIDTH-1)-1].
  - Write sum to the captured idx.
  - Addresses are strictly increasing, so there is no RAW hazard.
- DRAIN: Up_W=0, Done=1; the final write commits; -> IDLE.
- Timing: the Done cycle is N_INPUTS+1 cycles after the Start edge. Weights are readable via Rd_addr from the next cycle.
- Rd_data while Busy: holds its last value and Rd_addr is ignored (RAM read port is owned by UPDATE).
- Start while Busy: ignored, not queued.
- Start held high across Done: a new pass begins on the first IDLE edge.
- RST mid-UPDATE/DRAIN:
  - Pass aborts and stage-2 valid is cleared; no further write occurs.
  - No Done; Up_W drops in the next cycle; the CLEAR sweep reruns.
- Delta_w is treated as signed 8-bit; the full range -128..127 must be handled.

Decomposition:
- Package `perceptron_pkg`:
  - constants N_INPUTS, W_WIDTH, DELTA_WIDTH=8;
  - `state_t` enum {CLEAR, IDLE, UPDATE, DRAIN};
  - `weight_t` signed typedef;
  - saturating-add function.
- Sub-module `weight_ram`:
  - simple dual-port, one synchronous read port and one write port, depth N_INPUTS, width W_WIDTH;
  - no reset, contents initialised by CLEAR;
  - read port address muxed between idx (UPDATE) and Rd_addr (IDLE).

Test Plan (bench N_INPUTS=4, W_WIDTH=16 unless noted):
- Reset: RST pulse, then wait -> Busy=1 for exactly 4 cycles; then Rd_addr 0..3 -> Rd_data=0 each; Up_W=0, Done=0 throughout.
- Basic pass (LR_SHIFT=2): Start, drive Delta_w +1,0,-1,+1 on the Up_W cycles -> Up_W high exactly 4 cycles; Done one cycle later; weights 4,0,-4,4.
- Saturation (LR_SHIFT=8): two passes of Delta_w=127 -> 32512 then 32767. Two passes of -128 from zero -> -32768 then stays -32768.
- Start during Busy: assert Start on the 2nd Up_W cycle -> still exactly 4 Up_W pulses and one Done; no second pass.
- Reset abort: RST on the 3rd Up_W cycle -> Up_W low the next cycle; no Done; 4-cycle CLEAR; all weights read 0.
- Read latency: idle after the basic pass, Rd_addr=2 -> Rd_data=-4 (0xFFFC) one cycle later. Change Rd_addr while Busy -> Rd_data holds.

Source files
------------

// File: rtl/perceptron_pkg.sv
// Purpose: shared constants, types and saturating arithmetic for the perceptron weight path.
// Latency: none (declarations only).
// Backpressure: none.
//
// Contents:
//   N_INPUTS, W_WIDTH, DELTA_WIDTH  default sizing of the weight store and delta stream
//   state_t                         weight-update sequencer states
//   weight_t, delta_t               signed weight / delta types at the default widths
//   sat_add                         signed add clipped to a w-bit two's-complement range
package perceptron_pkg;

  localparam int N_INPUTS    = 8001;
  localparam int W_WIDTH     = 16;
  localparam int DELTA_WIDTH = 8;

  typedef enum logic [1:0] {
    CLEAR  = 2'd0,
    IDLE   = 2'd1,
    UPDATE = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  typedef logic signed [W_WIDTH-1:0]     weight_t;
  typedef logic signed [DELTA_WIDTH-1:0] delta_t;

  // Adds two sign-extended operands and clips the result to the range of a
  // w-bit signed number. Operands are carried at 64 bits so the raw sum can
  // never wrap for any w up to 32; callers keep the low w bits.
  function automatic logic signed [63:0] sat_add(
    input logic signed [63:0] a,
    input logic signed [63:0] b,
    input int unsigned        w
  );
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    s  = a + b;
    if (s > hi) begin
      return hi;
    end else if (s < lo) begin
      return lo;
    end
    return s;
  endfunction

endpackage

// File: rtl/weight_ram.sv
// Purpose: simple dual-port weight store, one synchronous read port and one write port.
// Latency: read data appears one cycle after a cycle with rd_en=1; writes land at the clock edge.
// Backpressure: none; read data holds its last value while rd_en=0.
//
// Ports:
//   Clk                      clock
//   wr_en, wr_addr, wr_data  write port (written at the rising edge when wr_en=1)
//   rd_en, rd_addr           read request
//   rd_data                  registered read data
// The array has no reset; the owner sweeps it to zero before first use.
module weight_ram #(
  parameter int DEPTH = 8001,
  parameter int W     = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                Clk,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic signed [W-1:0] wr_data,
  input  logic                rd_en,
  input  logic [AW-1:0]       rd_addr,
  output logic signed [W-1:0] rd_data
);

  logic signed [W-1:0] mem [DEPTH];

  always_ff @(posedge Clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge Clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/weight_update.sv
// Purpose: consume the delta-weight stream and saturating-accumulate scaled deltas into the weight store.
// Latency: a pass of N_INPUTS deltas ends with Done N_INPUTS+1 cycles after the Start edge; Rd_data is one cycle behind Rd_addr.
// Backpressure: none; the block paces the producer with one Up_W pulse per index, and Start is ignored while Busy.
//
// Ports:
//   Clk, RST   clock and synchronous active-high reset (reset reruns the zeroing sweep)
//   Start      request one update pass, sampled only in IDLE
//   Delta_w    signed delta for the current index, valid in every Up_W cycle
//   Up_W       shift request to the delta producer, one cycle per index
//   Busy       high whenever the block is not IDLE
//   Done       one-cycle pulse when the final write of a pass commits
//   Rd_addr    weight read address (honoured only while idle)
//   Rd_data    signed weight, one cycle after Rd_addr; holds while Busy
module weight_update #(
  parameter int N_INPUTS = perceptron_pkg::N_INPUTS,
  parameter int W_WIDTH  = perceptron_pkg::W_WIDTH,
  parameter int LR_SHIFT = 0,
  parameter int AW       = $clog2(N_INPUTS)
) (
  input  logic                                         Clk,
  input  logic                                         RST,
  input  logic                                         Start,
  input  logic signed [perceptron_pkg::DELTA_WIDTH-1:0] Delta_w,
  output logic                                         Up_W,
  output logic                                         Busy,
  output logic                                         Done,
  input  logic [AW-1:0]                                Rd_addr,
  output logic signed [W_WIDTH-1:0]                    Rd_data
);

  import perceptron_pkg::*;

  // Width of the accumulate datapath: a full weight plus a shifted 8-bit
  // delta fits without wrapping before the clip.
  localparam int SW = W_WIDTH + 9;

  state_t state;
  state_t state_nxt;

  logic [AW-1:0] idx;
  logic          idx_last;

  // Stage 2: delta and address captured in the UPDATE cycle, written the
  // cycle after, once the RAM has returned the old weight.
  logic                         s2_vld;
  logic [AW-1:0]                s2_idx;
  logic signed [DELTA_WIDTH-1:0] s2_delta;

  logic                      ram_we;
  logic [AW-1:0]             ram_wa;
  logic signed [W_WIDTH-1:0] ram_wd;
  logic                      ram_re;
  logic [AW-1:0]             ram_ra;
  logic signed [W_WIDTH-1:0] rd_q;

  logic signed [SW-1:0]      acc_ext;
  logic signed [SW-1:0]      step_ext;
  logic signed [63:0]        sum_sat;
  logic signed [W_WIDTH-1:0] wr_dat;

  // Read-port ownership tracking for Rd_data.
  logic                      rd_idle_q;
  logic signed [W_WIDTH-1:0] rd_hold;

  assign idx_last = (idx == AW'(N_INPUTS - 1));

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (RST) begin
      state <= CLEAR;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:   if (idx_last) state_nxt = IDLE;
      IDLE:    if (Start)    state_nxt = UPDATE;
      UPDATE:  if (idx_last) state_nxt = DRAIN;
      DRAIN:                 state_nxt = IDLE;
      default:               state_nxt = CLEAR;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs and RAM port steering
  // ---------------------------------------------------------------------
  always_comb begin
    Up_W   = 1'b0;
    Busy   = 1'b1;
    Done   = 1'b0;
    ram_re = 1'b0;
    ram_ra = Rd_addr;
    case (state)
      IDLE: begin
        Busy   = 1'b0;
        ram_re = 1'b1;
      end
      UPDATE: begin
        Up_W   = 1'b1;
        ram_re = 1'b1;
        ram_ra = idx;
      end
      DRAIN: begin
        Done   = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // The write port is shared by the zeroing sweep and stage 2; the two never
  // overlap because stage 2 is empty whenever the sweep runs. Writes are
  // suppressed in any cycle RST is high so an aborted pass leaves no trace.
  always_comb begin
    ram_we = 1'b0;
    ram_wa = s2_idx;
    ram_wd = wr_dat;
    if (!RST) begin
      if (state == CLEAR) begin
        ram_we = 1'b1;
        ram_wa = idx;
        ram_wd = '0;
      end else if (s2_vld) begin
        ram_we = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Index counter: walks the array in CLEAR and UPDATE, parked at 0 otherwise
  // ---------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (RST) begin
      idx <= '0;
    end else begin
      case (state)
        CLEAR, UPDATE: idx <= idx_last ? '0 : idx + AW'(1);
        default:       idx <= '0;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2 capture
  // ---------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (RST) begin
      s2_vld   <= 1'b0;
      s2_idx   <= '0;
      s2_delta <= '0;
    end else begin
      s2_vld <= (state == UPDATE);
      if (state == UPDATE) begin
        s2_idx   <= idx;
        s2_delta <= Delta_w;
      end
    end
  end

  // Accumulate: old weight plus delta scaled by the power-of-two learning
  // rate, clipped to the weight range. Addresses only increase during a
  // pass, so the weight read for idx k is never one still waiting to be
  // written.
  assign acc_ext  = SW'(rd_q);
  assign step_ext = SW'(s2_delta) <<< LR_SHIFT;
  assign sum_sat  = sat_add(64'(acc_ext), 64'(step_ext), W_WIDTH);
  assign wr_dat   = W_WIDTH'(sum_sat);

  weight_ram #(
    .DEPTH (N_INPUTS),
    .W     (W_WIDTH),
    .AW    (AW)
  ) u_ram (
    .Clk     (Clk),
    .wr_en   (ram_we),
    .wr_addr (ram_wa),
    .wr_data (ram_wd),
    .rd_en   (ram_re),
    .rd_addr (ram_ra),
    .rd_data (rd_q)
  );

  // ---------------------------------------------------------------------
  // Read-port result for the inference path
  // ---------------------------------------------------------------------
  // rd_q carries the Rd_addr lookup only in the cycle after an IDLE cycle;
  // once UPDATE takes the port over, the last idle lookup is replayed from
  // rd_hold so Rd_data stays still for the whole pass.
  always_ff @(posedge Clk) begin
    if (RST) begin
      rd_idle_q <= 1'b0;
      rd_hold   <= '0;
    end else begin
      rd_idle_q <= (state == IDLE);
      if (rd_idle_q) begin
        rd_hold <= rd_q;
      end
    end
  end

  assign Rd_data = rd_idle_q ? rd_q : rd_hold;

endmodule
